// File: rtl/cpu_encoder.sv
// cpu_encoder: symbolic 6502 instruction to machine-code byte stream.
// Takes one (mnemonic, mode, operand) request per handshake. Each output
// byte carries its program-RAM address. An illegal mnemonic/mode pair emits
// no bytes and raises err for one cycle.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    request handshake; in_mnem, in_mode, in_operand
//   org_load, org_addr   reload the address counter (IDLE only)
//   out_valid/out_ready  byte handshake; out_data, out_addr, out_last
//   err                  one-cycle pulse for an illegal request
//
// state | meaning
// IDLE  | waiting for a request or org_load
// OP    | presenting the opcode byte
// LO    | presenting operand[7:0]
// HI    | presenting operand[15:8]
// ERR   | illegal request, err pulse, no bytes
module cpu_encoder #(
   parameter int                ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] START_ADDR = 16'h0200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_mnem,
   input  logic [3:0]        in_mode,
   input  logic [15:0]       in_operand,
   input  logic              org_load,
   input  logic [ADDR_W-1:0] org_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              err
);

   localparam logic [3:0] M_IMPL = 4'd0,  M_ACC  = 4'd1,  M_IMM  = 4'd2,
                          M_ZPG  = 4'd3,  M_ZPGX = 4'd4,  M_ZPGY = 4'd5,
                          M_ABS  = 4'd6,  M_ABSX = 4'd7,  M_ABSY = 4'd8,
                          M_IND  = 4'd9,  M_XIND = 4'd10, M_INDY = 4'd11,
                          M_REL  = 4'd12;

   typedef enum logic [2:0] {S_IDLE, S_OP, S_LO, S_HI, S_ERR} state_t;

   // Returns {legal, opcode}. Groups 01/10/00 are built from the aaa-bbb-cc
   // field layout of the 6502 opcode matrix; the rest are direct lookups.
   function automatic logic [8:0] f_encode(input logic [5:0] mnem, input logic [3:0] mode);
      logic       ok;
      logic [2:0] aaa;
      logic [2:0] bbb;
      logic [7:0] op;
      ok  = 1'b0;
      aaa = mnem[2:0];
      bbb = 3'b000;
      op  = 8'h00;
      if (mnem < 6'd8) begin
         ok = 1'b1;
         case (mode)
            M_XIND:  bbb = 3'b000;
            M_ZPG:   bbb = 3'b001;
            M_IMM:   bbb = 3'b010;
            M_ABS:   bbb = 3'b011;
            M_INDY:  bbb = 3'b100;
            M_ZPGX:  bbb = 3'b101;
            M_ABSY:  bbb = 3'b110;
            M_ABSX:  bbb = 3'b111;
            default: ok  = 1'b0;
         endcase
         if (mnem == 6'd4 && mode == M_IMM) ok = 1'b0;
         op = {aaa, bbb, 2'b01};
      end else if (mnem < 6'd16) begin
         // codes 12/13 are STX/LDX, which index by Y instead of X
         ok = 1'b1;
         case (mode)
            M_ACC:   begin bbb = 3'b010; ok = (mnem < 6'd12); end
            M_IMM:   begin bbb = 3'b000; ok = (mnem == 6'd13); end
            M_ZPG:   bbb = 3'b001;
            M_ABS:   bbb = 3'b011;
            M_ZPGX:  begin bbb = 3'b101; ok = (mnem != 6'd12 && mnem != 6'd13); end
            M_ZPGY:  begin bbb = 3'b101; ok = (mnem == 6'd12 || mnem == 6'd13); end
            M_ABSX:  begin bbb = 3'b111; ok = (mnem != 6'd12 && mnem != 6'd13); end
            M_ABSY:  begin bbb = 3'b111; ok = (mnem == 6'd13); end
            default: ok = 1'b0;
         endcase
         op = {aaa, bbb, 2'b10};
      end else if (mnem < 6'd22) begin
         case (mode)
            M_ZPG:   bbb = 3'b001;
            M_ABS:   bbb = 3'b011;
            M_ZPGX:  bbb = 3'b101;
            M_ABSX:  bbb = 3'b111;
            default: bbb = 3'b000;
         endcase
         case (mnem)
            6'd16:   begin aaa = 3'b001; ok = (mode == M_ZPG || mode == M_ABS); end
            6'd17:   begin
                        aaa = (mode == M_IND) ? 3'b011 : 3'b010;
                        bbb = 3'b011;
                        ok  = (mode == M_ABS || mode == M_IND);
                     end
            6'd18:   begin aaa = 3'b100; ok = (mode == M_ZPG || mode == M_ZPGX || mode == M_ABS); end
            6'd19:   begin
                        aaa = 3'b101;
                        ok  = (mode == M_IMM || mode == M_ZPG || mode == M_ZPGX ||
                               mode == M_ABS || mode == M_ABSX);
                     end
            6'd20:   begin aaa = 3'b110; ok = (mode == M_IMM || mode == M_ZPG || mode == M_ABS); end
            default: begin aaa = 3'b111; ok = (mode == M_IMM || mode == M_ZPG || mode == M_ABS); end
         endcase
         op = {aaa, bbb, 2'b00};
      end else if (mnem < 6'd30) begin
         // branch condition index is mnem-22; 22 = 6 mod 8
         ok = (mode == M_REL);
         op = {mnem[2:0] - 3'd6, 5'b10000};
      end else if (mnem == 6'd31) begin
         ok = (mode == M_ABS);
         op = 8'h20;
      end else if (mnem < 6'd56) begin
         ok = (mode == M_IMPL);
         case (mnem)
            6'd30: op = 8'h00;  6'd32: op = 8'h40;  6'd33: op = 8'h60;
            6'd34: op = 8'h08;  6'd35: op = 8'h28;  6'd36: op = 8'h48;
            6'd37: op = 8'h68;  6'd38: op = 8'h88;  6'd39: op = 8'hA8;
            6'd40: op = 8'hC8;  6'd41: op = 8'hE8;  6'd42: op = 8'h18;
            6'd43: op = 8'h38;  6'd44: op = 8'h58;  6'd45: op = 8'h78;
            6'd46: op = 8'h98;  6'd47: op = 8'hB8;  6'd48: op = 8'hD8;
            6'd49: op = 8'hF8;  6'd50: op = 8'h8A;  6'd51: op = 8'h9A;
            6'd52: op = 8'hAA;  6'd53: op = 8'hBA;  6'd54: op = 8'hCA;
            default: op = 8'hEA;
         endcase
      end
      return {ok, op};
   endfunction

   function automatic logic [1:0] f_len(input logic [3:0] mode);
      case (mode)
         M_IMPL, M_ACC:                return 2'd1;
         M_ABS, M_ABSX, M_ABSY, M_IND: return 2'd3;
         default:                      return 2'd2;
      endcase
   endfunction

   state_t            r_state, w_next;
   logic [7:0]        r_opcode;
   logic [1:0]        r_len;
   logic [15:0]       r_operand;
   logic [ADDR_W-1:0] r_cnt;
   logic [8:0]        w_enc;
   logic              w_accept, w_xfer;

   assign w_enc    = f_encode(in_mnem, in_mode);
   assign in_ready = (r_state == S_IDLE) && !org_load;
   assign w_accept = in_valid && in_ready;
   assign w_xfer   = out_valid && out_ready;
   assign out_addr = r_cnt;

   always_comb begin
      w_next    = r_state;
      out_valid = 1'b0;
      out_data  = 8'h00;
      out_last  = 1'b0;
      err       = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept) w_next = w_enc[8] ? S_OP : S_ERR;
         S_OP: begin
            out_valid = 1'b1;
            out_data  = r_opcode;
            out_last  = (r_len == 2'd1);
            if (w_xfer) w_next = (r_len == 2'd1) ? S_IDLE : S_LO;
         end
         S_LO: begin
            out_valid = 1'b1;
            out_data  = r_operand[7:0];
            out_last  = (r_len == 2'd2);
            if (w_xfer) w_next = (r_len == 2'd2) ? S_IDLE : S_HI;
         end
         S_HI: begin
            out_valid = 1'b1;
            out_data  = r_operand[15:8];
            out_last  = 1'b1;
            if (w_xfer) w_next = S_IDLE;
         end
         S_ERR: begin
            err    = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_opcode  <= 8'h00;
         r_len     <= 2'd0;
         r_operand <= 16'h0000;
         r_cnt     <= START_ADDR;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_opcode  <= w_enc[7:0];
            r_len     <= f_len(in_mode);
            r_operand <= in_operand;
         end
         if (r_state == S_IDLE && org_load)
            r_cnt <= org_addr;
         else if (w_xfer)
            r_cnt <= r_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_cpu_encoder.sv
module tb_cpu_encoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_mnem = '0;
   logic [3:0]  in_mode = '0;
   logic [15:0] in_operand = '0;
   logic        org_load = 1'b0;
   logic [15:0] org_addr = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic [15:0] out_addr;
   logic        out_last;
   logic        err;

   int vectors = 0;
   int miscompares = 0;
   int m_cnt;
   localparam int N = -1;
   // documented opcode per [mnemonic][mode]; N = no such instruction
   // mode columns: IMPL ACC IMM ZPG ZPGX ZPGY ABS ABSX ABSY IND XIND INDY REL
   int ref_op [0:55][0:12];

   cpu_encoder #(.ADDR_W(16), .START_ADDR(16'h0200)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mnem(in_mnem), .in_mode(in_mode), .in_operand(in_operand),
      .org_load(org_load), .org_addr(org_addr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
      .err(err)
   );

   always #5 clk = ~clk;

   function automatic int ref_opcode(input int mn, input int md);
      if (mn > 55 || md > 12) return N;
      return ref_op[mn][md];
   endfunction

   function automatic int ref_len(input int md);
      if (md == 0 || md == 1) return 1;
      if (md >= 6 && md <= 9) return 3;
      return 2;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic accept(input int mn, input int md, input int opnd);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
      in_valid   = 1'b1;
      in_mnem    = mn[5:0];
      in_mode    = md[3:0];
      in_operand = opnd[15:0];
      tick();
      in_valid   = 1'b0;
      in_mnem    = 6'($urandom);
      in_mode    = 4'($urandom);
      in_operand = 16'($urandom);
   endtask

   task automatic emit(input int mn, input int md, input int opnd, input int stalls, input bit rnd);
      int op, len, i, guard, stall_left;
      int bytes[3];
      bit rdy;
      op = ref_opcode(mn, md);
      if (op < 0) begin
         chk("err_pulse", {31'b0, err}, 32'd1);
         chk("err_no_valid", {31'b0, out_valid}, 32'd0);
         chk("err_busy", {31'b0, in_ready}, 32'd0);
         tick();
         chk("err_clear", {31'b0, err}, 32'd0);
         chk("err_ready", {31'b0, in_ready}, 32'd1);
         chk("err_addr", {16'b0, out_addr}, m_cnt);
         return;
      end
      len = ref_len(md);
      bytes[0] = op;
      bytes[1] = opnd & 'hFF;
      bytes[2] = (opnd >> 8) & 'hFF;
      i = 0;
      guard = 0;
      stall_left = stalls;
      while (i < len && guard < 500) begin
         chk("valid", {31'b0, out_valid}, 32'd1);
         chk("data", {24'b0, out_data}, bytes[i]);
         chk("addr", {16'b0, out_addr}, m_cnt);
         chk("last", {31'b0, out_last}, (i == len - 1) ? 32'd1 : 32'd0);
         chk("busy", {31'b0, in_ready}, 32'd0);
         chk("no_err", {31'b0, err}, 32'd0);
         if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = rnd ? ($urandom_range(0, 99) < 70) : 1'b1;
         end
         rdy = out_ready;
         tick();
         guard++;
         if (rdy) begin
            i++;
            m_cnt = (m_cnt + 1) & 'hFFFF;
         end
      end
      chk("byte_timeout", guard < 500, 32'd1);
      out_ready = 1'b1;
      chk("done_valid", {31'b0, out_valid}, 32'd0);
      chk("done_ready", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic instr(input int mn, input int md, input int opnd, input int stalls, input bit rnd);
      accept(mn, md, opnd);
      emit(mn, md, opnd, stalls, rnd);
   endtask

   task automatic do_org(input int a);
      org_load = 1'b1;
      org_addr = a[15:0];
      #1;
      chk("org_ready_low", {31'b0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      org_load = 1'b0;
      m_cnt = a & 'hFFFF;
      #1;
      chk("org_addr", {16'b0, out_addr}, m_cnt);
   endtask

   initial begin
      int impl_ops[26];
      int br_ops[8];
      int mn, md, opnd, tries;

      for (int a = 0; a < 56; a++)
         for (int b = 0; b < 13; b++)
            ref_op[a][b] = N;
      ref_op[0]  = '{N, N,'h09,'h05,'h15, N,'h0D,'h1D,'h19, N,'h01,'h11, N};
      ref_op[1]  = '{N, N,'h29,'h25,'h35, N,'h2D,'h3D,'h39, N,'h21,'h31, N};
      ref_op[2]  = '{N, N,'h49,'h45,'h55, N,'h4D,'h5D,'h59, N,'h41,'h51, N};
      ref_op[3]  = '{N, N,'h69,'h65,'h75, N,'h6D,'h7D,'h79, N,'h61,'h71, N};
      ref_op[4]  = '{N, N,   N,'h85,'h95, N,'h8D,'h9D,'h99, N,'h81,'h91, N};
      ref_op[5]  = '{N, N,'hA9,'hA5,'hB5, N,'hAD,'hBD,'hB9, N,'hA1,'hB1, N};
      ref_op[6]  = '{N, N,'hC9,'hC5,'hD5, N,'hCD,'hDD,'hD9, N,'hC1,'hD1, N};
      ref_op[7]  = '{N, N,'hE9,'hE5,'hF5, N,'hED,'hFD,'hF9, N,'hE1,'hF1, N};
      ref_op[8]  = '{N,'h0A, N,'h06,'h16, N,'h0E,'h1E, N, N, N, N, N};
      ref_op[9]  = '{N,'h2A, N,'h26,'h36, N,'h2E,'h3E, N, N, N, N, N};
      ref_op[10] = '{N,'h4A, N,'h46,'h56, N,'h4E,'h5E, N, N, N, N, N};
      ref_op[11] = '{N,'h6A, N,'h66,'h76, N,'h6E,'h7E, N, N, N, N, N};
      ref_op[12] = '{N, N, N,'h86, N,'h96,'h8E, N, N, N, N, N, N};
      ref_op[13] = '{N, N,'hA2,'hA6, N,'hB6,'hAE, N,'hBE, N, N, N, N};
      ref_op[14] = '{N, N, N,'hC6,'hD6, N,'hCE,'hDE, N, N, N, N, N};
      ref_op[15] = '{N, N, N,'hE6,'hF6, N,'hEE,'hFE, N, N, N, N, N};
      ref_op[16] = '{N, N, N,'h24, N, N,'h2C, N, N, N, N, N, N};
      ref_op[17] = '{N, N, N, N, N, N,'h4C, N, N,'h6C, N, N, N};
      ref_op[18] = '{N, N, N,'h84,'h94, N,'h8C, N, N, N, N, N, N};
      ref_op[19] = '{N, N,'hA0,'hA4,'hB4, N,'hAC,'hBC, N, N, N, N, N};
      ref_op[20] = '{N, N,'hC0,'hC4, N, N,'hCC, N, N, N, N, N, N};
      ref_op[21] = '{N, N,'hE0,'hE4, N, N,'hEC, N, N, N, N, N, N};
      br_ops = '{'h10,'h30,'h50,'h70,'h90,'hB0,'hD0,'hF0};
      for (int k = 0; k < 8; k++) ref_op[22 + k][12] = br_ops[k];
      // BRK..NOP implied forms; JSR has none, it is absolute-only
      impl_ops = '{'h00, N,'h40,'h60,'h08,'h28,'h48,'h68,'h88,'hA8,'hC8,'hE8,'h18,
                   'h38,'h58,'h78,'h98,'hB8,'hD8,'hF8,'h8A,'h9A,'hAA,'hBA,'hCA,'hEA};
      for (int k = 0; k < 26; k++) ref_op[30 + k][0] = impl_ops[k];
      ref_op[31][6] = 'h20;

      m_cnt = 'h200;
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_last", {31'b0, out_last}, 32'd0);
      chk("rst_data", {24'b0, out_data}, 32'd0);
      chk("rst_addr", {16'b0, out_addr}, 32'h200);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", {31'b0, in_ready}, 32'd1);

      instr(5, 2, 'h0042, 0, 0);    // LDA #$42
      chk("lda_next_addr", {16'b0, out_addr}, 32'h202);
      instr(17, 9, 'h1234, 0, 0);   // JMP ($1234)
      instr(31, 6, 'hC000, 0, 0);   // JSR $C000
      instr(4, 2, 'h0011, 0, 0);    // STA # illegal
      instr(60, 0, 'h0000, 0, 0);   // illegal mnemonic
      instr(8, 1, 'h5555, 5, 0);    // ASL A under backpressure
      instr(28, 12, 'h00FE, 0, 0);  // BNE -2
      do_org('hFFFF);
      instr(13, 8, 'h1234, 0, 0);   // LDX $1234,Y across wrap
      chk("wrap_addr", {16'b0, out_addr}, 32'h0002);

      // reset while the operand-low byte is on the bus
      accept(4, 3, 'h0010);
      chk("sta_op", {24'b0, out_data}, 32'h85);
      out_ready = 1'b1;
      tick();
      m_cnt = (m_cnt + 1) & 'hFFFF;
      chk("sta_lo", {24'b0, out_data}, 32'h10);
      out_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'b0, out_valid}, 32'd0);
      chk("midrst_addr", {16'b0, out_addr}, 32'h200);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      m_cnt = 'h200;
      instr(55, 0, 'h0000, 0, 0);   // NOP -> EA@0200

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 99) < 10)
            do_org(($urandom_range(0, 3) == 0) ? 'hFFFE : int'($urandom_range(0, 'hFFFF)));
         opnd = int'($urandom_range(0, 'hFFFF));
         if ($urandom_range(0, 99) < 20) begin
            mn = int'($urandom_range(0, 63));
            md = int'($urandom_range(0, 15));
         end else begin
            tries = 0;
            do begin
               mn = int'($urandom_range(0, 55));
               md = int'($urandom_range(0, 12));
               tries++;
            end while (ref_op[mn][md] < 0 && tries < 200);
         end
         instr(mn, md, opnd, int'($urandom_range(0, 2)), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
